// File: rtl/i2s_pkg.sv
// Shared widths, frame layout and types for the I2S transmitter.
// The frame helper places each channel MSB-aligned in its own slot window.
package i2s_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int SLOT_W      = 16;
  localparam int BCLK_DIV    = 16;
  localparam int FRAME_SLOTS = 2 * SLOT_W;
  localparam int SLOT_CNT_W  = $clog2(FRAME_SLOTS);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tx_state_t;

  function automatic logic [FRAME_SLOTS-1:0] pack_frame(input stereo_sample_t s);
    logic [FRAME_SLOTS-1:0] f;
    f = '0;
    f[FRAME_SLOTS-1 -: SAMPLE_W] = s.left;
    f[SLOT_W-1 -: SAMPLE_W]      = s.right;
    return f;
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: bclk falls on every bit strobe and rises half a
// bit period later, giving a 50% duty clock with the rising edge mid-bit.
module i2s_bclk_gen
  import i2s_pkg::*;
(
  input  logic master_clk,
  input  logic rst,
  input  logic bit_clk_en,
  input  logic active,
  output logic bclk
);

  localparam int PH_W = $clog2(BCLK_DIV) + 1;
  localparam logic [PH_W-1:0] HALF = PH_W'(BCLK_DIV / 2);

  logic [PH_W-1:0] phase;

  // phase counts master_clk cycles since the last strobe (strobe cycle = 0)
  always_ff @(posedge master_clk) begin
    if (rst) begin
      phase <= '0;
      bclk  <= 1'b0;
    end else if (bit_clk_en) begin
      phase <= PH_W'(1);
      bclk  <= 1'b0;
    end else begin
      phase <= phase + PH_W'(1);
      if (active && phase == HALF) bclk <= 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-deep holding register behind a valid/ready
// handshake, frame shift register and slot counter. Build option
// I2S_TX_UNDERRUN_REPEAT_EN repeats the last sent pair on underrun instead of silence.
//
// state   | meaning
// ST_IDLE | no frame start seen yet; bclk, lrclk, sdata held low
// ST_RUN  | frames streaming, outputs follow the bit strobes
module i2s_tx
  import i2s_pkg::*;
(
  input  logic                master_clk,
  input  logic                rst,
  input  logic                sample_clk_en,
  input  logic                bit_clk_en,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] left,
  input  logic [SAMPLE_W-1:0] right,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);

  tx_state_t              state, state_nxt;
  logic                   fs, active, xfer, hold_full;
  stereo_sample_t         hold, underrun_src, frame_src;
  logic [FRAME_SLOTS-1:0] sreg;
  logic [SLOT_CNT_W-1:0]  slot, slot_nxt;

  assign fs           = bit_clk_en & sample_clk_en;
  assign active       = (state == ST_RUN) || fs;
  assign sample_ready = !hold_full;
  assign xfer         = sample_valid && !hold_full;
  assign slot_nxt     = fs ? '0 : slot + SLOT_CNT_W'(1);

  always_ff @(posedge master_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (fs) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  stereo_sample_t last_frame;

  always_ff @(posedge master_clk) begin
    if (rst)                    last_frame <= '0;
    else if (fs && hold_full)   last_frame <= hold;
  end

  assign underrun_src = last_frame;
`else
  assign underrun_src = '0;
`endif

  assign frame_src = hold_full ? hold : underrun_src;

  always_ff @(posedge master_clk) begin
    if (rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      slot      <= '0;
      sreg      <= '0;
      sdata     <= 1'b0;
      lrclk     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= fs && !hold_full;
      // a transfer on a frame start lands after the empty hold was sampled
      if (xfer) begin
        hold.left  <= left;
        hold.right <= right;
        hold_full  <= 1'b1;
      end else if (fs) begin
        hold_full  <= 1'b0;
      end
      if (bit_clk_en) begin
        slot <= slot_nxt;
        if (active) begin
          sdata <= sreg[FRAME_SLOTS-1];
          sreg  <= fs ? pack_frame(frame_src) : {sreg[FRAME_SLOTS-2:0], 1'b0};
          lrclk <= (slot_nxt >= SLOT_CNT_W'(SLOT_W));
        end
      end
    end
  end

  i2s_bclk_gen u_bclk_gen (
    .master_clk (master_clk),
    .rst        (rst),
    .bit_clk_en (bit_clk_en),
    .active     (state == ST_RUN),
    .bclk       (bclk)
  );

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: strobes come from a 512-cycle frame counter,
// each frame records sdata/lrclk per slot and compares against hand-built patterns.
module tb_i2s_tx;
  import i2s_pkg::*;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  localparam logic [31:0] LR_EXP = 32'hFFFF_0000;

  logic master_clk = 1'b0;
  logic rst = 1'b1;
  logic sample_clk_en = 1'b0;
  logic bit_clk_en = 1'b0;
  logic sample_valid = 1'b0;
  logic sample_ready, bclk, lrclk, sdata, underrun;
  logic [15:0] left = '0;
  logic [15:0] right = '0;
  int n_checks = 0;
  int n_fail = 0;
  int mcnt = 1;

  always #5 master_clk = ~master_clk;

  i2s_tx dut (
    .master_clk    (master_clk),
    .rst           (rst),
    .sample_clk_en (sample_clk_en),
    .bit_clk_en    (bit_clk_en),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .left          (left),
    .right         (right),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .underrun      (underrun)
  );

  task automatic tick();
    logic xf;
    xf = sample_valid && sample_ready;
    @(posedge master_clk);
    #1;
    if (xf) sample_valid = 1'b0;
    mcnt = (mcnt + 1) % 512;
    bit_clk_en = (mcnt % 16 == 0);
    sample_clk_en = (mcnt == 0);
  endtask

  function automatic logic [31:0] exp_slots(input logic [15:0] l, input logic [15:0] r,
                                            input logic prev);
    logic [31:0] e;
    e[0] = prev;
    for (int s = 1; s <= 16; s++) e[s] = l[16-s];
    for (int s = 17; s <= 31; s++) e[s] = r[32-s];
    return e;
  endfunction

  // Runs one frame starting at a frame-start strobe; up to two samples are offered mid-frame.
  task automatic run_frame(input int at1, input logic [15:0] l1, input logic [15:0] r1,
                           input int at2, input logic [15:0] l2, input logic [15:0] r2,
                           output logic [31:0] sd, output logic [31:0] lr,
                           output int ur_cnt, output int ur_first, output int bclk_err);
    logic b;
    sd = '0; lr = '0; ur_cnt = 0; ur_first = -1; bclk_err = 0;
    for (int i = 0; i < 512; i++) begin
      b = bit_clk_en;
      if (i == at1) begin sample_valid = 1'b1; left = l1; right = r1; end
      if (i == at2) begin sample_valid = 1'b1; left = l2; right = r2; end
      tick();
      if (b) begin sd[i/16] = sdata; lr[i/16] = lrclk; end
      if (underrun === 1'b1) begin
        if (ur_cnt == 0) ur_first = i;
        ur_cnt++;
      end
      if (bclk !== ((i % 16) >= 8)) bclk_err++;
    end
  endtask

  logic [31:0] sd, lr;
  int ur_cnt, ur_first, bclk_err;

  task automatic test_reset();
    int bad;
    bit found;
    rst = 1'b1;
    repeat (4) tick();
    n_checks++;
    if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_values: got %b want 00001", {bclk, lrclk, sdata, underrun, sample_ready});
    end
    rst = 1'b0;
    bad = 0;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (bit_clk_en && sample_clk_en) begin found = 1'b1; break; end
      tick();
      if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_before_fs: got %0d active cycles want 0", bad);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL fs_wait: got timeout want frame start");
    end
  endtask

  task automatic test_idle_frame();
    run_frame(100, 16'hA5C3, 16'h0F0F, 300, 16'h1234, 16'h8001, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 1 || ur_first != 0) begin
      n_fail++;
      $display("FAIL f1_underrun: got cnt %0d at %0d want 1 at 0", ur_cnt, ur_first);
    end
    n_checks++;
    if (sd !== 32'h0) begin
      n_fail++;
      $display("FAIL f1_silence: got %h want 00000000", sd);
    end
    n_checks++;
    if (lr !== LR_EXP) begin
      n_fail++;
      $display("FAIL f1_lrclk: got %h want %h", lr, LR_EXP);
    end
    n_checks++;
    if (bclk_err != 0) begin
      n_fail++;
      $display("FAIL f1_bclk: got %0d bad cycles want 0", bclk_err);
    end
    n_checks++;
    if (sample_ready !== 1'b0 || sample_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL f1_hold_full: got ready %b pending %b want 0 1", sample_ready, sample_valid);
    end
  endtask

  task automatic test_single_sample();
    run_frame(-1, '0, '0, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 0) begin
      n_fail++;
      $display("FAIL f2_underrun: got %0d want 0", ur_cnt);
    end
    n_checks++;
    if (sd !== exp_slots(16'hA5C3, 16'h0F0F, 1'b0)) begin
      n_fail++;
      $display("FAIL f2_sdata: got %h want %h", sd, exp_slots(16'hA5C3, 16'h0F0F, 1'b0));
    end
    n_checks++;
    if (lr !== LR_EXP || bclk_err != 0) begin
      n_fail++;
      $display("FAIL f2_clocks: got lr %h bclk_err %0d want %h 0", lr, bclk_err, LR_EXP);
    end
    n_checks++;
    if (sample_valid !== 1'b0 || sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL f2_second_accept: got pending %b ready %b want 0 0", sample_valid, sample_ready);
    end
  endtask

  task automatic test_back_to_back();
    run_frame(-1, '0, '0, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 0) begin
      n_fail++;
      $display("FAIL f3_underrun: got %0d want 0", ur_cnt);
    end
    n_checks++;
    if (sd !== exp_slots(16'h1234, 16'h8001, 1'b1)) begin
      n_fail++;
      $display("FAIL f3_sdata: got %h want %h", sd, exp_slots(16'h1234, 16'h8001, 1'b1));
    end
  endtask

  task automatic test_starve();
    logic [31:0] e;
    e = REP ? exp_slots(16'h1234, 16'h8001, 1'b1) : exp_slots(16'h0, 16'h0, 1'b1);
    run_frame(-1, '0, '0, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 1 || ur_first != 0) begin
      n_fail++;
      $display("FAIL f4_underrun: got cnt %0d at %0d want 1 at 0", ur_cnt, ur_first);
    end
    n_checks++;
    if (sd !== e) begin
      n_fail++;
      $display("FAIL f4_sdata: got %h want %h", sd, e);
    end
  endtask

  task automatic test_fs_collision();
    logic [31:0] e;
    sample_valid = 1'b1; left = 16'h7E81; right = 16'hC3A5;
    e = REP ? exp_slots(16'h1234, 16'h8001, 1'b1) : exp_slots(16'h0, 16'h0, 1'b0);
    run_frame(-1, '0, '0, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 1 || ur_first != 0) begin
      n_fail++;
      $display("FAIL f5_underrun: got cnt %0d at %0d want 1 at 0", ur_cnt, ur_first);
    end
    n_checks++;
    if (sd !== e) begin
      n_fail++;
      $display("FAIL f5_sdata: got %h want %h", sd, e);
    end
    n_checks++;
    if (sample_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL f5_captured: got ready %b want 0", sample_ready);
    end
    run_frame(100, 16'hBEEF, 16'h5555, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    e = exp_slots(16'h7E81, 16'hC3A5, REP);
    n_checks++;
    if (ur_cnt != 0) begin
      n_fail++;
      $display("FAIL f6_underrun: got %0d want 0", ur_cnt);
    end
    n_checks++;
    if (sd !== e) begin
      n_fail++;
      $display("FAIL f6_sdata: got %h want %h", sd, e);
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    bit found;
    for (int i = 0; i < 165; i++) begin
      if (i == 50) begin sample_valid = 1'b1; left = 16'hCAFE; right = 16'h0001; end
      tick();
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) begin
      n_fail++;
      $display("FAIL midreset_values: got %b want 00001", {bclk, lrclk, sdata, underrun, sample_ready});
    end
    rst = 1'b0;
    bad = 0;
    found = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (bit_clk_en && sample_clk_en) begin found = 1'b1; break; end
      tick();
      if ({bclk, lrclk, sdata, underrun, sample_ready} !== 5'b00001) bad++;
    end
    n_checks++;
    if (bad != 0 || !found) begin
      n_fail++;
      $display("FAIL midreset_idle: got %0d active cycles found %0d want 0 1", bad, found);
    end
    run_frame(-1, '0, '0, -1, '0, '0, sd, lr, ur_cnt, ur_first, bclk_err);
    n_checks++;
    if (ur_cnt != 1 || ur_first != 0) begin
      n_fail++;
      $display("FAIL f8_underrun: got cnt %0d at %0d want 1 at 0", ur_cnt, ur_first);
    end
    n_checks++;
    if (sd !== 32'h0) begin
      n_fail++;
      $display("FAIL f8_discarded: got %h want 00000000", sd);
    end
    n_checks++;
    if (lr !== LR_EXP || bclk_err != 0) begin
      n_fail++;
      $display("FAIL f8_clocks: got lr %h bclk_err %0d want %h 0", lr, bclk_err, LR_EXP);
    end
  endtask

  initial begin
    test_reset();
    test_idle_frame();
    test_single_sample();
    test_back_to_back();
    test_starve();
    test_fs_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
